r_peak_detector: RTL

Consumes the filtered lead sample stream (`signed_data_out`/`data_valid_out` of `fir_filter`) and detects R-peaks with an adaptive amplitude threshold. Per beat it reports the R-R interval in samples and a heart rate in BPM from a sequential divider. It sits beside `scrolling_graph` on the `fir_filter` output. Its outputs drive the LEDs and a threshold overlay on the graph.

---
 rtl/r_peak_detector.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/r_peak_detector.sv
// R-peak detector: adaptive threshold on |sample|, refractory FSM,
// R-R interval counter and a restoring divider producing BPM.
module r_peak_detector #(
    parameter int DATA_RESOLUTION    = 11,
    parameter int SAMPLES_PER_MINUTE = 9900,
    parameter int REFRACTORY_SAMPLES = 33,
    parameter int MAX_RR_SAMPLES     = 495,
    parameter int MIN_THRESHOLD      = 64,
    parameter int DECAY_SHIFT        = 6,
    parameter int RR_WIDTH           = $clog2(MAX_RR_SAMPLES + 1)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic signed [DATA_RESOLUTION-1:0] data_in,
    input  logic                              data_valid_in,
    output logic                              beat_out,
    output logic [RR_WIDTH-1:0]               rr_out,
    output logic [7:0]                        bpm_out,
    output logic                              bpm_valid_out,
    output logic                              no_signal_out,
    output logic [DATA_RESOLUTION-1:0]        threshold_out
);

    localparam int DW   = DATA_RESOLUTION;
    localparam int Q    = $clog2(SAMPLES_PER_MINUTE + 1);
    localparam int QCW  = $clog2(Q + 1);
    localparam int REFW = $clog2(REFRACTORY_SAMPLES + 1);

    localparam logic [DW-1:0]       MAG_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]       MAG_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]       MIN_THR = DW'(MIN_THRESHOLD);
    localparam logic [RR_WIDTH-1:0] RR_MAX  = RR_WIDTH'(MAX_RR_SAMPLES);
    localparam logic [REFW-1:0]     REF_END = REFW'(REFRACTORY_SAMPLES - 1);
    localparam logic [Q-1:0]        DIVIDND = Q'(SAMPLES_PER_MINUTE);

    typedef enum logic [1:0] {
        SEARCH,
        IN_PEAK,
        REFRACTORY
    } state_e;

    state_e              state_q;
    logic [DW-1:0]       peak_q;
    logic [REFW-1:0]     refr_q;
    logic [RR_WIDTH-1:0] rr_cnt_q;
    logic                have_prev_q;

    logic                busy_q;
    logic [QCW-1:0]      cnt_q;
    logic [Q-1:0]        quo_q;
    logic [RR_WIDTH-1:0] rem_q;
    logic [RR_WIDTH-1:0] dvs_q;

    function automatic logic [DW-1:0] thr_of(input logic [DW-1:0] p);
        return ((p >> 1) < MIN_THR) ? MIN_THR : (p >> 1);
    endfunction

    logic [DW-1:0]       mag;
    logic [DW-1:0]       thr;
    logic [DW-1:0]       peak_d;
    logic                above;
    logic                beat_hit;
    logic [RR_WIDTH-1:0] rr_inc;
    logic [RR_WIDTH:0]   shifted;
    logic                ge;
    logic [RR_WIDTH-1:0] rem_d;

    always_comb begin
        mag = data_in;
        if (data_in[DW-1]) begin
            mag = (data_in == MAG_NEG) ? MAG_MAX : $unsigned(-data_in);
        end
        thr    = thr_of(peak_q);
        above  = (mag >= thr);
        peak_d = (mag > peak_q) ? mag : peak_q - (peak_q >> DECAY_SHIFT);
        beat_hit = data_valid_in && (state_q == IN_PEAK) && !above;
        rr_inc = (rr_cnt_q == RR_MAX) ? rr_cnt_q : rr_cnt_q + 1'b1;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted = {rem_q, quo_q[Q-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        rem_d   = ge ? RR_WIDTH'(shifted - {1'b0, dvs_q}) : shifted[RR_WIDTH-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= SEARCH;
            peak_q        <= '0;
            refr_q        <= '0;
            rr_cnt_q      <= '0;
            have_prev_q   <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            beat_out      <= 1'b0;
            rr_out        <= '0;
            bpm_out       <= '0;
            bpm_valid_out <= 1'b0;
            no_signal_out <= 1'b1;
            threshold_out <= MIN_THR;
        end else begin
            beat_out      <= beat_hit;
            bpm_valid_out <= 1'b0;

            if (data_valid_in) begin
                peak_q        <= peak_d;
                threshold_out <= thr_of(peak_d);

                unique case (state_q)
                    SEARCH: begin
                        if (above) state_q <= IN_PEAK;
                    end
                    IN_PEAK: begin
                        if (!above) begin
                            state_q <= REFRACTORY;
                            refr_q  <= '0;
                        end
                    end
                    REFRACTORY: begin
                        if (refr_q == REF_END) state_q <= SEARCH;
                        else refr_q <= refr_q + 1'b1;
                    end
                    default: state_q <= SEARCH;
                endcase

                // A beat in the timeout sample takes priority over the timeout
                if (beat_hit) begin
                    rr_cnt_q      <= '0;
                    have_prev_q   <= 1'b1;
                    no_signal_out <= 1'b0;
                    if (have_prev_q) rr_out <= rr_cnt_q + 1'b1;
                end else begin
                    rr_cnt_q <= rr_inc;
                    if (rr_inc == RR_MAX) begin
                        no_signal_out <= 1'b1;
                        bpm_out       <= '0;
                        have_prev_q   <= 1'b0;
                    end
                end
            end

            if (beat_hit && have_prev_q) begin
                busy_q <= 1'b1;
                cnt_q  <= QCW'(Q);
                quo_q  <= DIVIDND;
                rem_q  <= '0;
                dvs_q  <= rr_cnt_q + 1'b1;
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                    quo_q <= {quo_q[Q-2:0], ge};
                    rem_q <= rem_d;
                end else begin
                    busy_q        <= 1'b0;
                    bpm_valid_out <= 1'b1;
                    bpm_out       <= (quo_q > Q'(255)) ? 8'd255 : quo_q[7:0];
                end
            end
        end
    end

endmodule
